// File: rtl/pattern_gen_32.sv
// Counter / PRBS31 test-stream source on a valid/ready interface with single-word error injection.
// Define PATGEN_STATS_EN to implement the words_sent / errs_injected counters (tied to 0 otherwise).
module pattern_gen_32 #(
  parameter int          TARGET_CHIP  = 2,
  parameter logic [31:0] DEFAULT_SEED = 32'h0000_0001,
  parameter logic [31:0] ERR_MASK     = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  input  logic [31:0] seed,
  input  logic [15:0] burst_len,
  input  logic        inject_err,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] words_sent,
  output logic [15:0] errs_injected
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [31:0] seed_q, seed_d;
  logic [15:0] blen_q, blen_d, cnt_q, cnt_d;
  logic [31:0] pat_q, pat_d, dout_q, dout_d;
  logic [30:0] lfsr_q, lfsr_d;
  logic        vld_q, vld_d, busy_q, busy_d, done_q, done_d;
  logic        stop_q, stop_d, inj_q, inj_d;
  logic        hs, last;
  logic [30:0] seed31;
  logic [62:0] step;

  // Advance the LFSR 32 bits; first generated bit lands in word[31]. Returns {word, new_state}.
  function automatic logic [62:0] prbs_word(input logic [30:0] s_in);
    logic [30:0] s;
    logic [31:0] w;
    logic        b;
    s = s_in;
    w = '0;
    for (int i = 31; i >= 0; i--) begin
      b    = s[30] ^ s[27];
      s    = {s[29:0], b};
      w[i] = b;
    end
    return {w, s};
  endfunction

  assign hs     = vld_q & dout_ready;
  assign last   = hs & (stop | stop_q | ((blen_q != 16'd0) && (cnt_q == blen_q - 16'd1)));
  assign seed31 = (seed_q[30:0] == 31'd0) ? DEFAULT_SEED[30:0] : seed_q[30:0];
  assign step   = prbs_word((state_q == LOAD) ? seed31 : lfsr_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    seed_d  = seed_q;
    blen_d  = blen_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    lfsr_d  = lfsr_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    stop_d  = stop_q;
    inj_d   = inj_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        mode_d  = mode;
        seed_d  = seed;
        blen_d  = burst_len;
        cnt_d   = '0;
        stop_d  = 1'b0;
        inj_d   = 1'b0;
      end
      LOAD: begin
        state_d = RUN;
        vld_d   = 1'b1;
        inj_d   = inj_q | inject_err;
        if (mode_q) begin
          pat_d  = step[62:31];
          lfsr_d = step[30:0];
        end else begin
          pat_d  = seed_q;
        end
        dout_d = pat_d ^ (inj_d ? ERR_MASK : 32'd0);
      end
      RUN: begin
        stop_d = stop_q | stop;
        inj_d  = inj_q | inject_err;
        if (hs) begin
          cnt_d = cnt_q + 16'd1;
          inj_d = inject_err;
          if (mode_q) begin
            pat_d  = step[62:31];
            lfsr_d = step[30:0];
          end else begin
            pat_d  = pat_q + 32'd1;
          end
        end
        // Corruption only touches the output word; the generator always runs clean.
        if (last) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          done_d  = 1'b1;
          stop_d  = 1'b0;
          inj_d   = 1'b0;
        end else begin
          dout_d = pat_d ^ (inj_d ? ERR_MASK : 32'd0);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      seed_q  <= '0;
      blen_q  <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      lfsr_q  <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
      inj_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      blen_q  <= blen_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      lfsr_q  <= lfsr_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      stop_q  <= stop_d;
      inj_q   <= inj_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef PATGEN_STATS_EN
  logic [31:0] ws_q;
  logic [15:0] ei_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ws_q <= '0;
      ei_q <= '0;
    end else if (state_q == IDLE && start) begin
      ws_q <= '0;
      ei_q <= '0;
    end else if (hs) begin
      ws_q <= ws_q + 32'd1;
      if (inj_q && ei_q != 16'hFFFF) ei_q <= ei_q + 16'd1;
    end
  end

  assign words_sent    = ws_q;
  assign errs_injected = ei_q;
`else
  assign words_sent    = 32'd0;
  assign errs_injected = 16'd0;
`endif

endmodule

// File: tb/tb_pattern_gen_32.sv
// Self-checking bench for pattern_gen_32: vector table, random runs vs. a queue-based
// PRBS31/counter model, and hand sequences for injection, stop, restart and reset.
module tb_pattern_gen_32;
  localparam logic [31:0] DSEED = 32'h0000_0001;
  localparam logic [31:0] EMASK = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        arst, start, stop, mode, inject_err, dout_ready;
  logic [31:0] seed;
  logic [15:0] burst_len;
  logic [31:0] dout, words_sent;
  logic        dout_valid, busy, done;
  logic [15:0] errs_injected;

  int checks = 0;
  int passed = 0;

  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];
  int          sched_dones;
  logic        sched_done_after;

  typedef struct {
    bit          m;
    logic [31:0] sd;
    logic [15:0] bl;
    int          rmode;
    logic [31:0] first;
  } vec_t;

  always #5 clk = ~clk;

  pattern_gen_32 dut (
    .clk(clk), .arst(arst), .start(start), .stop(stop), .mode(mode), .seed(seed),
    .burst_len(burst_len), .inject_err(inject_err), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .done(done), .words_sent(words_sent),
    .errs_injected(errs_injected)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef PATGEN_STATS_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  // Reference stream: counter is seed+k; PRBS31 is x[n] = x[n-31] ^ x[n-28], seed bit 30 oldest.
  task automatic build_exp(input bit m, input logic [31:0] sd, input int n);
    bit          hist[$];
    logic [30:0] s;
    logic [31:0] w;
    bit          x;
    exp_q.delete();
    if (!m) begin
      for (int k = 0; k < n; k++) exp_q.push_back(sd + k);
    end else begin
      s = sd[30:0];
      if (s == 31'd0) s = DSEED[30:0];
      for (int i = 30; i >= 0; i--) hist.push_back(s[i]);
      for (int k = 0; k < n; k++) begin
        w = '0;
        for (int b = 0; b < 32; b++) begin
          x = hist[hist.size()-31] ^ hist[hist.size()-28];
          hist.push_back(x);
          w = {w[30:0], x};
        end
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic run_burst(input string tag, input bit m, input logic [31:0] sd,
                           input logic [15:0] bl, input int rmode,
                           input bit has_first, input logic [31:0] exp_first);
    int          k = 0, cyc = 0;
    bit          stall = 0;
    logic [31:0] held = '0, first = '0;
    build_exp(m, sd, int'(bl));
    @(negedge clk);
    mode = m; seed = sd; burst_len = bl; start = 1'b1; dout_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " lat1"}, {30'd0, busy, dout_valid}, 32'd2);
    @(negedge clk);
    chk({tag, " lat2"}, {31'd0, dout_valid}, 32'd1);
    while (!done && cyc < 2000) begin
      if (stall) chk({tag, " hold"}, dout, held);
      case (rmode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = (cyc % 3 == 2);
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      if (dout_valid && dout_ready) begin
        if (k == 0) first = dout;
        if (k < exp_q.size()) chk({tag, " word"}, dout, exp_q[k]);
        else chk({tag, " extra"}, k, exp_q.size());
        k++;
        stall = 0;
      end else if (dout_valid) begin
        stall = 1;
        held  = dout;
      end
      cyc++;
      @(negedge clk);
    end
    dout_ready = 1'b0;
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " count"}, k, {16'd0, bl});
    chk({tag, " vld_end"}, {31'd0, dout_valid}, 32'd0);
    chk({tag, " words_sent"}, words_sent, stat({16'd0, bl}));
    if (has_first) chk({tag, " first"}, first, exp_first);
    @(negedge clk);
    chk({tag, " done_once"}, {31'd0, done}, 32'd0);
  endtask

  // Counter-mode run with per-cycle ready/inject/stop/start patterns (bit c = RUN cycle c).
  task automatic run_sched(input logic [31:0] sd, input logic [15:0] bl, input logic [63:0] rp,
                           input logic [63:0] ip, input logic [63:0] sp, input logic [63:0] stp);
    int c = 0;
    acc_q.delete();
    sched_dones = 0;
    @(negedge clk);
    mode = 1'b0; seed = sd; burst_len = bl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    while (c < 64) begin
      if (done) begin
        sched_dones++;
        break;
      end
      dout_ready = rp[c]; inject_err = ip[c]; stop = sp[c]; start = stp[c];
      if (stp[c]) seed = sd + 32'h1000;
      if (dout_valid && dout_ready) acc_q.push_back(dout);
      c++;
      @(negedge clk);
    end
    dout_ready = 1'b0; inject_err = 1'b0; stop = 1'b0; start = 1'b0;
    @(negedge clk);
    sched_done_after = done;
  endtask

  task automatic chk_seq(input string tag, input logic [31:0] want[$]);
    chk({tag, " n"}, acc_q.size(), want.size());
    for (int i = 0; i < want.size() && i < acc_q.size(); i++) chk({tag, " w"}, acc_q[i], want[i]);
    chk({tag, " dones"}, sched_dones, 1);
    chk({tag, " done_once"}, {31'd0, sched_done_after}, 32'd0);
  endtask

  initial begin
    vec_t        vecs[5];
    logic [31:0] want[$];
    bit          rm;
    logic [15:0] rbl;

    arst = 1'b1; start = 0; stop = 0; mode = 0; inject_err = 0; dout_ready = 0;
    seed = '0; burst_len = '0;
    repeat (2) @(negedge clk);
    chk("rst dout", dout, 32'd0);
    chk("rst flags", {29'd0, dout_valid, busy, done}, 32'd0);
    chk("rst words_sent", words_sent, 32'd0);
    chk("rst errs", {16'd0, errs_injected}, 32'd0);
    arst = 1'b0;

    vecs[0] = '{0, 32'hFFFF_FFFE, 16'd4, 0, 32'hFFFF_FFFE};
    vecs[1] = '{1, 32'h0000_0000, 16'd3, 0, 32'h0000_0012};
    vecs[2] = '{1, 32'h8000_0000, 16'd2, 0, 32'h0000_0012};
    vecs[3] = '{0, 32'h0000_0005, 16'd5, 1, 32'h0000_0005};
    vecs[4] = '{0, 32'h0000_1234, 16'd1, 0, 32'h0000_1234};
    for (int i = 0; i < 5; i++)
      run_burst($sformatf("vec%0d", i), vecs[i].m, vecs[i].sd, vecs[i].bl, vecs[i].rmode, 1'b1,
                vecs[i].first);
    build_exp(0, 32'hFFFF_FFFE, 4);
    chk("wrap last", exp_q[3], 32'h0000_0001);

    for (int i = 0; i < 6; i++) begin
      rm  = 1'($urandom_range(0, 1));
      rbl = 16'($urandom_range(1, 12));
      run_burst($sformatf("rnd%0d", i), rm, $urandom, rbl, 2, 1'b0, 32'd0);
    end

    // Inject while stalled on word 2.
    run_sched(32'd0, 16'd6, ~64'h4, 64'h4, 64'h0, 64'h0);
    want = '{32'd0, 32'd1, 32'd3, 32'd3, 32'd4, 32'd5};
    chk_seq("inj", want);
    chk("inj errs", {16'd0, errs_injected}, stat(32'd1));
    // Inject coincident with the word-2 handshake corrupts word 3.
    run_sched(32'd0, 16'd6, ~64'h0, 64'h4, 64'h0, 64'h0);
    want = '{32'd0, 32'd1, 32'd2, 32'd2, 32'd4, 32'd5};
    chk_seq("inj_hs", want);
    chk("inj_hs errs", {16'd0, errs_injected}, stat(32'd1));
    // Two pulses while pending merge into a single corruption.
    run_sched(32'd0, 16'd6, ~64'h1C, 64'hC, 64'h0, 64'h0);
    want = '{32'd0, 32'd1, 32'd3, 32'd3, 32'd4, 32'd5};
    chk_seq("inj_merge", want);
    chk("inj_merge errs", {16'd0, errs_injected}, stat(32'd1));

    // Continuous run, stop during backpressure, start mid-run ignored.
    run_sched(32'd100, 16'd0, ~64'h70, 64'h0, 64'h20, 64'h4);
    want = '{32'd100, 32'd101, 32'd102, 32'd103, 32'd104};
    chk_seq("stop", want);
    chk("stop idle hold", dout, 32'd104);
    chk("stop words_sent", words_sent, stat(32'd5));

    // Asynchronous reset mid-run.
    @(negedge clk);
    mode = 0; seed = 32'd7; burst_len = 16'd0; start = 1'b1; dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 arst = 1'b1;
    #1;
    chk("arst flags", {29'd0, dout_valid, busy, done}, 32'd0);
    chk("arst dout", dout, 32'd0);
    chk("arst words_sent", words_sent, 32'd0);
    @(negedge clk);
    arst = 1'b0; dout_ready = 1'b0;
    run_burst("post_rst", 0, 32'd7, 16'd3, 0, 1'b1, 32'd7);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
